axi_read_responder: RTL and testbench

- Slave-side consumer of the 49-bit AXI AR payload delivered by the AR clock-domain-crossing FIFO.
- Accepts one read burst at a time and walks the burst addresses into a single-port synchronous SRAM with 1-cycle read latency.
- Emits AXI R beats (ID, data, response, last) under valid/ready flow control, with a 2-entry output buffer.
- Sits on the slave side of the AR/R channel pair, in the same clock domain as the SRAM.

---
 rtl/axi_read_responder.sv | 172 +++++++++++++++++
 tb/tb_axi_read_responder.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_responder.sv
// AXI read-burst responder: accepts one AR at a time, walks burst addresses into a
// 1-cycle-latency SRAM and returns R beats via a 2-entry buffer. Optional: AXI_RD_DECERR_EN.
module axi_read_responder #(
  parameter int unsigned ID_W      = 8,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_W+ADDR_W+8:0]  ar_payload_i,
  input  logic                    ar_valid_i,
  output logic                    ar_ready_o,
  output logic                    mem_cs_o,
  output logic [ADDR_W-3:0]       mem_addr_o,
  input  logic [DATA_W-1:0]       mem_rdata_i,
  output logic [ID_W-1:0]         r_id_o,
  output logic [DATA_W-1:0]       r_data_o,
  output logic [1:0]              r_resp_o,
  output logic                    r_last_o,
  output logic                    r_valid_o,
  input  logic                    r_ready_i
);

  localparam int unsigned PAY_W = ID_W + ADDR_W + 9;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic                illegal_q;
  logic [4:0]          issued_q;
  logic                inflight_q;
  logic [1:0]          infl_resp_q;
  logic                infl_last_q;
  logic [DATA_W-1:0]   buf_data [2];
  logic [1:0]          buf_resp [2];
  logic                buf_last [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          buf_count;

  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [3:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic                ar_illegal;

  assign ar_id    = ar_payload_i[PAY_W-1 -: ID_W];
  assign ar_addr  = ar_payload_i[ADDR_W+8:9];
  assign ar_len   = ar_payload_i[8:5];
  assign ar_size  = ar_payload_i[4:2];
  assign ar_burst = ar_payload_i[1:0];

  // WRAP only supports power-of-two beat counts
  assign ar_illegal = (ar_size > 3'd2) || (ar_burst == 2'b11) ||
                      ((ar_burst == 2'b10) && !((ar_len == 4'd1) || (ar_len == 4'd3) ||
                                                (ar_len == 4'd7) || (ar_len == 4'd15)));

  logic              pop, pop_buf, capture, issue, beat_last, done, head_buf;
  logic [2:0]        occ;
  logic [1:0]        beat_resp;
  logic [ADDR_W-1:0] size_bytes, wrap_mask, addr_next;
  logic [DATA_W-1:0] infl_data;

  always_comb begin
    head_buf   = (buf_count != 2'd0);
    r_valid_o  = head_buf | inflight_q;
    pop        = r_valid_o & r_ready_i;
    pop_buf    = pop & head_buf;
    // an in-flight beat popped straight off the SRAM bypass never enters the buffer
    capture    = inflight_q & ~(pop & ~head_buf);
    occ        = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
    beat_last  = (issued_q == {1'b0, len_q});
    issue      = (state == BURST) && (issued_q <= {1'b0, len_q}) && (occ < 3'd2);
`ifdef AXI_RD_DECERR_EN
    beat_resp  = illegal_q ? RESP_SLVERR :
                 (addr_q >= ADDR_W'(MEM_BYTES)) ? RESP_DECERR : RESP_OKAY;
`else
    beat_resp  = illegal_q ? RESP_SLVERR : RESP_OKAY;
`endif
    mem_cs_o   = issue && (beat_resp == RESP_OKAY);
    mem_addr_o = addr_q[ADDR_W-1:2];
    infl_data  = (infl_resp_q == RESP_OKAY) ? mem_rdata_i : '0;
    r_id_o     = id_q;
    r_data_o   = head_buf ? buf_data[rd_ptr] : infl_data;
    r_resp_o   = head_buf ? buf_resp[rd_ptr] : infl_resp_q;
    r_last_o   = head_buf ? buf_last[rd_ptr] : infl_last_q;
    done       = pop & r_last_o;
    ar_ready_o = (state == IDLE);
  end

  // burst address sequencing
  always_comb begin
    size_bytes = ADDR_W'(1) << size_q[1:0];
    wrap_mask  = (ADDR_W'({1'b0, len_q} + 5'd1) << size_q[1:0]) - ADDR_W'(1);
    case (burst_q)
      2'b01:   addr_next = (addr_q & ~(size_bytes - ADDR_W'(1))) + size_bytes;
      2'b10:   addr_next = (addr_q & ~wrap_mask) | ((addr_q + size_bytes) & wrap_mask);
      default: addr_next = addr_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      illegal_q   <= 1'b0;
      issued_q    <= '0;
      inflight_q  <= 1'b0;
      infl_resp_q <= RESP_OKAY;
      infl_last_q <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      buf_count   <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_data[i] <= '0;
        buf_resp[i] <= RESP_OKAY;
        buf_last[i] <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (ar_valid_i) begin
            id_q      <= ar_id;
            addr_q    <= ar_addr;
            len_q     <= ar_len;
            size_q    <= ar_size;
            burst_q   <= ar_burst;
            illegal_q <= ar_illegal;
            issued_q  <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (issue) begin
            addr_q   <= addr_next;
            issued_q <= issued_q + 5'd1;
          end
          if (done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      inflight_q <= issue;
      if (issue) begin
        infl_resp_q <= beat_resp;
        infl_last_q <= beat_last;
      end
      if (capture) begin
        buf_data[wr_ptr] <= infl_data;
        buf_resp[wr_ptr] <= infl_resp_q;
        buf_last[wr_ptr] <= infl_last_q;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop_buf) rd_ptr <= ~rd_ptr;
      buf_count <= buf_count + 2'(capture) - 2'(pop_buf);
    end
  end

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: vector table of AR requests, SRAM model returning the
// word address as data, and a scoreboard of expected R beats built from each AR handshake.
module tb_axi_read_responder;

  localparam int unsigned MEM_BYTES = 65536;

  logic        clk, rst_n;
  logic [48:0] ar_payload_i;
  logic        ar_valid_i, ar_ready_o;
  logic        mem_cs_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_rdata_i;
  logic [7:0]  r_id_o;
  logic [31:0] r_data_o;
  logic [1:0]  r_resp_o;
  logic        r_last_o, r_valid_o, r_ready_i;

  axi_read_responder #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .rst_n(rst_n),
    .ar_payload_i(ar_payload_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .mem_cs_o(mem_cs_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .r_id_o(r_id_o), .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_last_o(r_last_o),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: word address comes back as data one cycle later
  always @(posedge clk) if (mem_cs_o) mem_rdata_i <= 32'(mem_addr_o);

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic [7:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          stall;
    int          exp_cs;
    logic [29:0] exp_maddr;
    int          cs_at_stall;
  } vec_t;

  beat_t sb[$];
  int    n_vec = 0, n_err = 0;
  int    cyc = 0, cs_count = 0, pop_cyc = 0;
  logic  held_valid = 1'b0;
  logic [42:0] held;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [3:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int i);
    logic [31:0] sbytes, wl, base;
    sbytes = 32'd1 << size;
    case (burst)
      2'b00: return a;
      2'b01: return (i == 0) ? a : (a / sbytes) * sbytes + 32'(i) * sbytes;
      default: begin
        wl   = (32'(len) + 32'd1) * sbytes;
        base = (a / wl) * wl;
        return base + ((a - base) + 32'(i) * sbytes) % wl;
      end
    endcase
  endfunction

  // monitor: scoreboard push on AR handshake, pop/compare on R handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      held_valid = 1'b0;
    end else begin
      if (ar_valid_i && ar_ready_o) begin
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        ill;
        logic [31:0] a;
        beat_t       e;
        len   = ar_payload_i[8:5];
        size  = ar_payload_i[4:2];
        burst = ar_payload_i[1:0];
        ill   = (size > 3'd2) || (burst == 2'b11) ||
                (burst == 2'b10 && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
        for (int i = 0; i <= int'(len); i++) begin
          a      = model_addr(ar_payload_i[40:9], len, size, burst, i);
          e.id   = ar_payload_i[48:41];
          e.resp = ill ? 2'b10 : 2'b00;
`ifdef AXI_RD_DECERR_EN
          if (!ill && a >= 32'(MEM_BYTES)) e.resp = 2'b11;
`endif
          e.data = (e.resp == 2'b00) ? (a >> 2) : 32'd0;
          e.last = (i == int'(len));
          sb.push_back(e);
        end
      end
      if (mem_cs_o) cs_count++;
      if (held_valid) begin
        chk("r_hold_valid", 64'(r_valid_o), 64'd1);
        if (r_valid_o) chk("r_hold_fields", 64'({r_id_o, r_data_o, r_resp_o, r_last_o}), 64'(held));
      end
      held_valid = 1'b0;
      if (r_valid_o) begin
        if (r_ready_i) begin
          if (sb.size() == 0) begin
            chk("unexpected_beat", 64'(r_data_o), 64'hDEAD);
          end else begin
            beat_t e;
            e = sb.pop_front();
            chk("r_id", 64'(r_id_o), 64'(e.id));
            chk("r_data", 64'(r_data_o), 64'(e.data));
            chk("r_resp", 64'(r_resp_o), 64'(e.resp));
            chk("r_last", 64'(r_last_o), 64'(e.last));
            if (r_last_o) pop_cyc = cyc;
          end
        end else begin
          held_valid = 1'b1;
          held       = {r_id_o, r_data_o, r_resp_o, r_last_o};
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && ar_ready_o && !r_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    wait_idle();
    r_ready_i = (v.stall == 0);
    @(posedge clk); #1;
    ar_valid_i   = 1'b1;
    ar_payload_i = {v.id, v.addr, v.len, v.size, v.burst};
    @(negedge clk);
    chk("ar_ready", 64'(ar_ready_o), 64'd1);
    @(posedge clk); #1;
    ar_valid_i = 1'b0;
    cs_count   = 0;
    @(negedge clk);
    chk("first_cs", 64'(mem_cs_o), 64'(v.exp_cs != 0));
    if (v.exp_cs != 0) chk("first_maddr", 64'(mem_addr_o), 64'(v.exp_maddr));
    @(negedge clk);
    chk("first_valid", 64'(r_valid_o), 64'd1);
    if (v.stall > 0) begin
      repeat (v.stall) @(posedge clk);
      chk("cs_at_stall", 64'(cs_count), 64'(v.cs_at_stall));
      #1 r_ready_i = 1'b1;
    end
    wait_idle();
    chk("cs_total", 64'(cs_count), 64'(v.exp_cs));
  endtask

  vec_t vt[11];

  initial begin
    vt[0]  = '{8'h05, 32'h0000_0100, 4'd0,  3'd2, 2'b01, 0, 1,  30'h40,   0};
    vt[1]  = '{8'h11, 32'h0000_1000, 4'd3,  3'd2, 2'b01, 5, 4,  30'h400,  2};
    vt[2]  = '{8'h22, 32'h0000_2018, 4'd3,  3'd2, 2'b10, 0, 4,  30'h806,  0};
    vt[3]  = '{8'h33, 32'h0000_2000, 4'd2,  3'd2, 2'b11, 0, 0,  30'h0,    0};
    vt[4]  = '{8'h44, 32'h0000_3003, 4'd3,  3'd1, 2'b01, 0, 4,  30'hC00,  0};
    vt[5]  = '{8'h55, 32'h0000_4444, 4'd2,  3'd2, 2'b00, 0, 3,  30'h1111, 0};
    vt[6]  = '{8'h66, 32'h0000_0040, 4'd0,  3'd3, 2'b01, 0, 0,  30'h0,    0};
    vt[7]  = '{8'h77, 32'h0000_0080, 4'd2,  3'd2, 2'b10, 0, 0,  30'h0,    0};
    vt[8]  = '{8'h88, 32'h0000_500A, 4'd7,  3'd1, 2'b10, 0, 8,  30'h1402, 0};
`ifdef AXI_RD_DECERR_EN
    vt[9]  = '{8'h99, 32'(MEM_BYTES - 4), 4'd1, 3'd2, 2'b01, 0, 1, 30'h3FFF, 0};
`else
    vt[9]  = '{8'h99, 32'(MEM_BYTES - 4), 4'd1, 3'd2, 2'b01, 0, 2, 30'h3FFF, 0};
`endif
    vt[10] = '{8'hFF, 32'h0000_0077, 4'd15, 3'd0, 2'b01, 0, 16, 30'h1D,  0};

    rst_n = 1'b0; ar_valid_i = 1'b0; ar_payload_i = '0; r_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_r_valid", 64'(r_valid_o), 64'd0);
    chk("rst_mem_cs", 64'(mem_cs_o), 64'd0);
    chk("rst_ar_ready", 64'(ar_ready_o), 64'd1);
    chk("rst_r_last", 64'(r_last_o), 64'd0);
    chk("rst_r_resp", 64'(r_resp_o), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) run_vec(vt[i]);

    // back-to-back: second AR held valid through the first burst
    wait_idle();
    r_ready_i = 1'b1;
    @(posedge clk); #1;
    ar_valid_i   = 1'b1;
    ar_payload_i = {8'h41, 32'h0000_0600, 4'd1, 3'd2, 2'b01};
    @(negedge clk);
    @(posedge clk); #1;
    ar_payload_i = {8'h42, 32'h0000_0700, 4'd0, 3'd2, 2'b01};
    @(negedge clk);
    chk("busy_ar_ready", 64'(ar_ready_o), 64'd0);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        if (ar_ready_o) begin
          seen = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("b2b_seen", 64'(seen), 64'd1);
      if (seen) chk("b2b_gap", 64'(cyc), 64'(pop_cyc + 1));
    end
    @(posedge clk); #1;
    ar_valid_i = 1'b0;
    wait_idle();

    // reset in the middle of a stalled burst
    r_ready_i = 1'b0;
    @(posedge clk); #1;
    ar_valid_i   = 1'b1;
    ar_payload_i = {8'h5A, 32'h0000_0800, 4'd7, 3'd2, 2'b01};
    @(posedge clk); #1;
    ar_valid_i = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_r_valid", 64'(r_valid_o), 64'd0);
    chk("midrst_ar_ready", 64'(ar_ready_o), 64'd1);
    chk("midrst_mem_cs", 64'(mem_cs_o), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    r_ready_i = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_r_valid", 64'(r_valid_o), 64'd0);
    run_vec(vt[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
